// File: rtl/regfile_pkg.sv
// Shared definitions for the one-hot driven register file: default sizing,
// the hardwired-zero index and the common illegal-select test.
package regfile_pkg;

   localparam int unsigned DEF_WIDTH = 4;
   localparam int unsigned DEF_NREGS = 2 ** DEF_WIDTH;
   localparam int unsigned ZERO_IDX  = 0;

   // Widest select vector the illegal test accepts (covers WIDTH up to 6).
   localparam int unsigned SEL_MAX_W = 64;

   // A select is illegal when two or more bits are set. v & (v-1) clears the
   // lowest set bit, so a nonzero result means popcount > 1.
   function automatic logic sel_illegal(input logic [SEL_MAX_W-1:0] v);
      return (v & (v - SEL_MAX_W'(1))) != '0;
   endfunction

endpackage

// File: rtl/regfile_onehot_chk.sv
// Classifies a one-hot select vector as empty or illegal (two or more bits).
module onehot_chk
   import regfile_pkg::*;
#(
   parameter int unsigned N = DEF_NREGS
) (
   input  logic [N-1:0] sel,
   output logic         is_zero,
   output logic         is_illegal
);

   // Pure combinational classification shared by both select inputs.
   always_comb begin
      is_zero    = (sel == '0);
      is_illegal = sel_illegal(SEL_MAX_W'(sel));
   end

endmodule

// File: rtl/regfile_onehot.sv
// Register file with integrated busy scoreboard, driven by one-hot write and
// issue selects. Register 0 reads as zero and is never busy.
// Optional feature: define REGFILE_BYPASS_EN to forward same-edge write data
// (and the post-update busy flag) to a read of the same register.
module regfile_onehot
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH  = DEF_WIDTH,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2**WIDTH-1:0]   wr_sel,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2**WIDTH-1:0]   iss_sel,
   input  logic [WIDTH-1:0]      ra_addr,
   input  logic [WIDTH-1:0]      rb_addr,
   output logic [DATA_W-1:0]     ra_data,
   output logic [DATA_W-1:0]     rb_data,
   output logic                  ra_busy,
   output logic                  rb_busy,
   output logic [2**WIDTH-1:0]   busy,
   output logic                  sel_err
);

   localparam int unsigned NREGS = 2 ** WIDTH;

   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  busy_q;
   logic [NREGS-1:0]  busy_nxt;
   logic [NREGS-1:0]  wr_en;
   logic [NREGS-1:0]  iss_en;
   logic              wr_zero, wr_ill;
   logic              iss_zero, iss_ill;

   onehot_chk #(.N(NREGS)) u_wr_chk (
      .sel        (wr_sel),
      .is_zero    (wr_zero),
      .is_illegal (wr_ill)
   );

   onehot_chk #(.N(NREGS)) u_iss_chk (
      .sel        (iss_sel),
      .is_zero    (iss_zero),
      .is_illegal (iss_ill)
   );

   // Qualified per-register enables; an illegal select suppresses its whole operation.
   always_comb begin
      wr_en  = '0;
      iss_en = '0;
      if (!wr_ill && !wr_zero) begin
         wr_en = wr_sel;
      end
      if (!iss_ill && !iss_zero) begin
         iss_en = iss_sel;
      end
      wr_en[ZERO_IDX]  = 1'b0;
      iss_en[ZERO_IDX] = 1'b0;
      // Issue applied after write so a new producer wins over the retiring one.
      busy_nxt = (busy_q & ~wr_en) | iss_en;
      busy_nxt[ZERO_IDX] = 1'b0;
   end

   // Register storage; index 0 stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 1; i < int'(NREGS); i++) begin
            if (wr_en[i]) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // Busy scoreboard and sticky select-error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         sel_err <= 1'b0;
      end else begin
         busy_q  <= busy_nxt;
         sel_err <= sel_err | wr_ill | iss_ill;
      end
   end

   assign busy = busy_q;

   // Registered read ports; address 0 forces zero data and not-busy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra_data <= '0;
         ra_busy <= 1'b0;
         rb_data <= '0;
         rb_busy <= 1'b0;
      end else begin
         if (ra_addr == WIDTH'(ZERO_IDX)) begin
            ra_data <= '0;
            ra_busy <= 1'b0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_en[ra_addr]) begin
            ra_data <= wr_data;
            ra_busy <= iss_en[ra_addr];
         end
`endif
         else begin
            ra_data <= regs[ra_addr];
            ra_busy <= busy_q[ra_addr];
         end

         if (rb_addr == WIDTH'(ZERO_IDX)) begin
            rb_data <= '0;
            rb_busy <= 1'b0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_en[rb_addr]) begin
            rb_data <= wr_data;
            rb_busy <= iss_en[rb_addr];
         end
`endif
         else begin
            rb_data <= regs[rb_addr];
            rb_busy <= busy_q[rb_addr];
         end
      end
   end

endmodule
